// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, step states,
// IR field positions and the strobe bundle handed from decoder to top.
package ctrl_pkg;
  localparam int OPW   = 5;
  localparam int IR_W  = 32;
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00001;
  localparam logic [OPW-1:0] OP_AND  = 5'b00010;
  localparam logic [OPW-1:0] OP_OR   = 5'b00011;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00100;
  localparam logic [OPW-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b00110;
  localparam logic [OPW-1:0] OP_ANDI = 5'b00111;
  localparam logic [OPW-1:0] OP_LD   = 5'b01000;
  localparam logic [OPW-1:0] OP_ST   = 5'b01001;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01010;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01011;
  localparam logic [OPW-1:0] OP_BR   = 5'b01100;
  localparam logic [OPW-1:0] OP_JUMP = 5'b01101;
  localparam logic [OPW-1:0] OP_HALT = 5'b11111;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout;
    logic hiin, hiout, loin, loout;
    logic zin, zhighout, zlowout, yin;
    logic mdrin, mdrout, marin;
    logic pcin, pcout, incpc, irin, cout;
    logic conin, read, write;
    logic [OPW-1:0] opcode;
  } strobes_t;
endpackage

// File: rtl/ctrl_step_decode.sv
// Combinational step decoder: (state, opcode, con_ff) -> strobes, next step,
// and a flag marking the final step of an instruction.
module ctrl_step_decode
  import ctrl_pkg::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] op,
  input  logic           con_ff,
  output strobes_t       strb,
  output state_t         next_state,
  output logic           last
);
  always_comb begin
    strb       = '0;
    next_state = S_RST;
    last       = 1'b0;
    unique case (state)
      S_RST: next_state = S_T0;
      S_T0: begin
        strb.pcout = 1'b1; strb.marin = 1'b1; strb.incpc = 1'b1; strb.zin = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        strb.zlowout = 1'b1; strb.pcin = 1'b1; strb.read = 1'b1; strb.mdrin = 1'b1;
        next_state = S_T2;
      end
      S_T2: begin
        strb.mdrout = 1'b1; strb.irin = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        next_state = S_T4;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_ADDI, OP_ORI, OP_ANDI: begin
            strb.grb = 1'b1; strb.rout = 1'b1; strb.yin = 1'b1;
          end
          OP_LD, OP_ST: begin
            strb.grb = 1'b1; strb.baout = 1'b1; strb.yin = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            strb.gra = 1'b1; strb.rout = 1'b1; strb.yin = 1'b1;
          end
          OP_BR: begin
            strb.gra = 1'b1; strb.rout = 1'b1; strb.conin = 1'b1;
          end
          OP_JUMP: begin
            strb.gra = 1'b1; strb.rout = 1'b1; strb.pcin = 1'b1;
            next_state = S_T0; last = 1'b1;
          end
          OP_HALT: next_state = S_HALT;
          default: begin next_state = S_T0; last = 1'b1; end
        endcase
      end
      S_T4: begin
        next_state = S_T5;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR: begin
            strb.grc = 1'b1; strb.rout = 1'b1; strb.zin = 1'b1; strb.opcode = op;
          end
          OP_ADDI, OP_ORI, OP_ANDI: begin
            strb.cout = 1'b1; strb.zin = 1'b1; strb.opcode = op;
          end
          OP_LD, OP_ST: begin
            strb.cout = 1'b1; strb.zin = 1'b1; strb.opcode = OP_ADD;
          end
          OP_MUL, OP_DIV: begin
            strb.grb = 1'b1; strb.rout = 1'b1; strb.zin = 1'b1; strb.opcode = op;
          end
          OP_BR: begin
            strb.pcout = 1'b1; strb.yin = 1'b1;
          end
          default: begin next_state = S_T0; last = 1'b1; end
        endcase
      end
      S_T5: begin
        next_state = S_T6;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_ADDI, OP_ORI, OP_ANDI: begin
            strb.zlowout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1;
            next_state = S_T0; last = 1'b1;
          end
          OP_LD, OP_ST: begin
            strb.zlowout = 1'b1; strb.marin = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            strb.zlowout = 1'b1; strb.loin = 1'b1;
          end
          OP_BR: begin
            strb.cout = 1'b1; strb.zin = 1'b1; strb.opcode = OP_ADD;
          end
          default: begin next_state = S_T0; last = 1'b1; end
        endcase
      end
      S_T6: begin
        next_state = S_T0;
        last       = 1'b1;
        case (op)
          OP_LD: begin
            strb.read = 1'b1; strb.mdrin = 1'b1;
            next_state = S_T7; last = 1'b0;
          end
          OP_ST: begin
            strb.gra = 1'b1; strb.rout = 1'b1; strb.mdrin = 1'b1;
            next_state = S_T7; last = 1'b0;
          end
          OP_MUL, OP_DIV: begin
            strb.zhighout = 1'b1; strb.hiin = 1'b1;
          end
          OP_BR: begin
            // Branch target is committed only when the condition flop is set
            strb.zlowout = con_ff; strb.pcin = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        next_state = S_T0;
        last       = 1'b1;
        case (op)
          OP_LD: begin strb.mdrout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
          OP_ST: strb.write = 1'b1;
          default: ;
        endcase
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: state register plus stop/halt handling;
// all strobe decoding lives in ctrl_step_decode.
module control_unit
  import ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            con_ff,
  input  logic            stop,
  output logic Gra, output logic Grb, output logic Grc,
  output logic Rin, output logic Rout, output logic BAout,
  output logic HIin, output logic HIout, output logic LOin, output logic LOout,
  output logic Zin, output logic Zhighout, output logic Zlowout, output logic Yin,
  output logic MDRin, output logic MDRout, output logic MARin,
  output logic PCin, output logic PCout, output logic IncPC, output logic IRin,
  output logic Cout, output logic CONin,
  output logic read, output logic write,
  output logic [OPW-1:0] opcode,
  output logic run
);
  state_t   state, state_nx, dec_next;
  strobes_t strb;
  logic     last;
  logic     unused_ir;

  assign unused_ir = ^ir[OP_LO-1:0];

  ctrl_step_decode u_dec (
    .state      (state),
    .op         (ir[OP_HI:OP_LO]),
    .con_ff     (con_ff),
    .strb       (strb),
    .next_state (dec_next),
    .last       (last)
  );

  always_ff @(posedge clock or negedge clear)
    if (!clear) state <= S_RST;
    else        state <= state_nx;

  // stop only takes effect on the edge that would otherwise return to fetch
  always_comb begin
    state_nx = dec_next;
    if (last && stop) state_nx = S_HALT;
  end

  always_comb begin
    Gra = strb.gra; Grb = strb.grb; Grc = strb.grc;
    Rin = strb.rin; Rout = strb.rout; BAout = strb.baout;
    HIin = strb.hiin; HIout = strb.hiout; LOin = strb.loin; LOout = strb.loout;
    Zin = strb.zin; Zhighout = strb.zhighout; Zlowout = strb.zlowout; Yin = strb.yin;
    MDRin = strb.mdrin; MDRout = strb.mdrout; MARin = strb.marin;
    PCin = strb.pcin; PCout = strb.pcout; IncPC = strb.incpc; IRin = strb.irin;
    Cout = strb.cout; CONin = strb.conin;
    read = strb.read; write = strb.write;
    opcode = strb.opcode;
    run = (state != S_RST) && (state != S_HALT);
  end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed instructions push expected
// per-cycle strobe vectors; a negedge monitor pops and compares.
module tb_control_unit;
  logic clock = 1'b0, clear = 1'b0, con_ff = 1'b0, stop = 1'b0;
  logic [31:0] ir = 32'h0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, HIin, HIout, LOin, LOout;
  logic Zin, Zhighout, Zlowout, Yin, MDRin, MDRout, MARin;
  logic PCin, PCout, IncPC, IRin, Cout, CONin, read, write, run;
  logic [4:0] opcode;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .Yin(Yin),
    .MDRin(MDRin), .MDRout(MDRout), .MARin(MARin),
    .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin),
    .Cout(Cout), .CONin(CONin), .read(read), .write(write),
    .opcode(opcode), .run(run)
  );

  always #5 clock = ~clock;

  localparam logic [30:0] WR = 31'h1, RD = 31'h2, CONI = 31'h4, COUT = 31'h8;
  localparam logic [30:0] IRIN = 31'h10, INCPC = 31'h20, PCOUT = 31'h40, PCIN = 31'h80;
  localparam logic [30:0] MARIN = 31'h100, MDROUT = 31'h200, MDRIN = 31'h400, YIN = 31'h800;
  localparam logic [30:0] ZLO = 31'h1000, ZHI = 31'h2000, ZIN = 31'h4000, LOOUT = 31'h8000;
  localparam logic [30:0] LOIN = 31'h1_0000, HIOUT = 31'h2_0000, HIIN = 31'h4_0000;
  localparam logic [30:0] BAOUT = 31'h8_0000, ROUT = 31'h10_0000, RIN = 31'h20_0000;
  localparam logic [30:0] GRC = 31'h40_0000, GRB = 31'h80_0000, GRA = 31'h100_0000;
  localparam logic [30:0] RUN = 31'h4000_0000;
  localparam logic [30:0] F0 = RUN | PCOUT | MARIN | INCPC | ZIN;
  localparam logic [30:0] F1 = RUN | ZLO | PCIN | RD | MDRIN;
  localparam logic [30:0] F2 = RUN | MDROUT | IRIN;

  function automatic logic [30:0] opv(input logic [4:0] o);
    return {1'b0, o, 25'd0};
  endfunction

  wire [30:0] act = {run, opcode, Gra, Grb, Grc, Rin, Rout, BAout, HIin, HIout, LOin, LOout,
                     Zin, Zhighout, Zlowout, Yin, MDRin, MDRout, MARin,
                     PCin, PCout, IncPC, IRin, Cout, CONin, read, write};

  logic [30:0] exp_q[$];
  string       tag_q[$];
  int          vectors = 0, miscompares = 0;
  logic [30:0] e;
  string       t;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", t, act, e);
      end
    end
    if (clear) begin
      vectors++;
      if ($countones({Rout, BAout, PCout, MDRout, Zlowout, Zhighout, HIout, LOout}) > 1
          || (read && write)) begin
        miscompares++;
        $display("FAIL bus_invariant: drivers %b rd %b wr %b expected <=1 driver, not rd&wr",
                 {Rout, BAout, PCout, MDRout, Zlowout, Zhighout, HIout, LOout}, read, write);
      end
    end
  end

  task automatic push(input logic [30:0] v, input string tg);
    exp_q.push_back(v);
    tag_q.push_back(tg);
  endtask

  task automatic fetch(input string tg);
    push(F0, {tg, "_T0"}); push(F1, {tg, "_T1"}); push(F2, {tg, "_T2"});
  endtask

  // Enters T0 on the next rising edge, then covers n sampled cycles.
  task automatic go(input logic [31:0] instr, input logic cf, input int n, input int stop_at);
    @(posedge clock); #1;
    ir = instr; con_ff = cf;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock); #1;
      if (i == stop_at) stop = 1'b1;
    end
  endtask

  task automatic idle(input int n, input string tg);
    for (int i = 0; i < n; i++) push(31'h0, tg);
    for (int i = 0; i < n; i++) begin @(negedge clock); #1; end
  endtask

  task automatic do_reset();
    clear = 1'b0;
    push(31'h0, "reset");
    @(negedge clock); #1;
    clear = 1'b1;
  endtask

  initial begin
    push(31'h0, "reset_initial");
    @(negedge clock); #1;
    clear = 1'b1;

    fetch("ori");
    push(RUN | GRB | ROUT | YIN, "ori_T3");
    push(RUN | COUT | ZIN | opv(5'b00110), "ori_T4");
    push(RUN | ZLO | GRA | RIN, "ori_T5");
    go(32'h3288_0005, 1'b0, 6, 0);

    fetch("ld");
    push(RUN | GRB | BAOUT | YIN, "ld_T3");
    push(RUN | COUT | ZIN, "ld_T4");
    push(RUN | ZLO | MARIN, "ld_T5");
    push(RUN | RD | MDRIN, "ld_T6");
    push(RUN | MDROUT | GRA | RIN, "ld_T7");
    go(32'h4000_0000, 1'b0, 8, 0);

    fetch("st");
    push(RUN | GRB | BAOUT | YIN, "st_T3");
    push(RUN | COUT | ZIN, "st_T4");
    push(RUN | ZLO | MARIN, "st_T5");
    push(RUN | GRA | ROUT | MDRIN, "st_T6");
    push(RUN | WR, "st_T7");
    go(32'h4800_0000, 1'b0, 8, 0);

    for (int c = 0; c < 2; c++) begin
      fetch("br");
      push(RUN | GRA | ROUT | CONI, "br_T3");
      push(RUN | PCOUT | YIN, "br_T4");
      push(RUN | COUT | ZIN, "br_T5");
      push((c == 1) ? (RUN | ZLO | PCIN) : RUN, (c == 1) ? "br_taken_T6" : "br_nottaken_T6");
      go(32'h6000_0000, c[0], 7, 0);
    end

    fetch("mul");
    push(RUN | GRA | ROUT | YIN, "mul_T3");
    push(RUN | GRB | ROUT | ZIN | opv(5'b01010), "mul_T4");
    push(RUN | ZLO | LOIN, "mul_T5");
    push(RUN | ZHI | HIIN, "mul_T6");
    go(32'h5000_0000, 1'b0, 7, 0);

    fetch("div");
    push(RUN | GRA | ROUT | YIN, "div_T3");
    push(RUN | GRB | ROUT | ZIN | opv(5'b01011), "div_T4");
    push(RUN | ZLO | LOIN, "div_T5");
    push(RUN | ZHI | HIIN, "div_T6");
    go(32'h5800_0000, 1'b0, 7, 0);

    fetch("jump");
    push(RUN | GRA | ROUT | PCIN, "jump_T3");
    go(32'h6800_0000, 1'b0, 4, 0);

    fetch("undef");
    push(RUN, "undef_T3");
    go(32'h8000_0000, 1'b0, 4, 0);

    fetch("add_abort");
    push(RUN | GRB | ROUT | YIN, "add_abort_T3");
    push(RUN | GRC | ROUT | ZIN, "add_abort_T4");
    go(32'h0000_0000, 1'b0, 5, 0);
    do_reset();

    fetch("resume_sub");
    push(RUN | GRB | ROUT | YIN, "sub_T3");
    push(RUN | GRC | ROUT | ZIN | opv(5'b00001), "sub_T4");
    push(RUN | ZLO | GRA | RIN, "sub_T5");
    go(32'h0800_0000, 1'b0, 6, 0);

    fetch("add_stop");
    push(RUN | GRB | ROUT | YIN, "add_stop_T3");
    push(RUN | GRC | ROUT | ZIN, "add_stop_T4");
    push(RUN | ZLO | GRA | RIN, "add_stop_T5");
    go(32'h0000_0000, 1'b0, 6, 5);
    idle(3, "halt_after_stop");
    stop = 1'b0;
    idle(2, "halt_sticky");
    do_reset();

    fetch("halt_op");
    push(RUN, "halt_op_T3");
    push(31'h0, "halt_op_state");
    push(31'h0, "halt_op_state");
    go(32'hF800_0000, 1'b0, 6, 0);
    do_reset();

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
